uart_debug_loader: RTL and testbench

//  Host-to-core half of the UART debug link: parses command packets from the uart RXbuffer/RXready

---
 rtl/uart_debug_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_debug_loader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_loader.sv
// uart_debug_loader
//
// Host-to-core half of the UART debug link. Parses command packets arriving on
// the uart receive byte stream, loads 32-bit control words into program ROM, and
// either single-steps or free-runs the core clock. Every packet gets exactly one
// ACK (0x06) or NAK (0x15) byte. Top forwards that byte to the uart transmit path.
//
// Packets (multi-byte fields little-endian):
//   0x01 WRITE : addrLo addrHi d0 d1 d2 d3 -> romAddr={addrHi,addrLo}, romData={d3,d2,d1,d0}
//   0x02 STEP  : n  -> n core clock cycles (n=0 means 256), NAK while free-running
//   0x03 RUN   : m  -> running=m[0]
//
// Optional feature: define CMD_CHECKSUM_EN to require one trailing byte per
// packet. That byte is the XOR of the command byte and all payload bytes. On a
// mismatch the packet is NAKed and has no side effect.
//
// Parameters:
//   TIMEOUT_CYCLES  max clock cycles between bytes of one packet (must be >= 2)
//   ADDR_W          ROM address width
//   WORD_W          control word width (4 payload bytes, i.e. 32)
//
// Ports:
//   CLK       in   system clock
//   RST       in   synchronous reset, active-high
//   rxData    in   received byte
//   rxReady   in   one-cycle strobe, rxData valid
//   romWrite  out  one-cycle ROM write strobe
//   romAddr   out  ROM write address, held until next write
//   romData   out  ROM write data, held until next write
//   stepClk   out  core clock, idles high
//   running   out  free-run mode active
//   ackValid  out  one-cycle strobe, ackCode valid
//   ackCode   out  0x06 ACK / 0x15 NAK
//   errFlag   out  sticky: a byte was dropped because the loader was busy
module uart_debug_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned WORD_W         = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rxData,
  input  logic              rxReady,
  output logic              romWrite,
  output logic [ADDR_W-1:0] romAddr,
  output logic [WORD_W-1:0] romData,
  output logic              stepClk,
  output logic              running,
  output logic              ackValid,
  output logic [7:0]        ackCode,
  output logic              errFlag
);

  localparam logic [7:0] CmdWrite = 8'h01;
  localparam logic [7:0] CmdStep  = 8'h02;
  localparam logic [7:0] CmdRun   = 8'h03;
  localparam logic [7:0] AckByte  = 8'h06;
  localparam logic [7:0] NakByte  = 8'h15;

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The NAK must be visible exactly TIMEOUT_CYCLES after the last byte. The
  // counter is 0 in the cycle after that byte, so the flag is raised on the
  // edge that ends the cycle where the counter holds TIMEOUT_CYCLES-2.
  localparam logic [TmoW-1:0] TmoFire = TmoW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    StIdle,
    StPayload,
    StCsum,
    StExec,
    StStepLo,
    StStepHi
  } state_e;

  state_e          state;
  logic [7:0]      cmd;
  logic [2:0]      cnt;
  logic [2:0]      last_idx;
  logic [7:0]      pay     [6];
  logic [7:0]      pay_now [6];
  logic [8:0]      steps;
  logic [TmoW-1:0] tmo;
  logic            waiting;
  logic            timed_out;
  logic            exec_now;
  logic            exec_ok;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign last_idx  = (cmd == CmdWrite) ? 3'd5 : 3'd0;
  assign waiting   = (state == StPayload) || (state == StCsum);
  assign timed_out = waiting && !rxReady && (tmo == TmoFire);

  // Payload as it will look once the byte arriving this cycle is stored. This
  // lets the command execute on the same edge that accepts its final byte.
  always_comb begin
    pay_now = pay;
    if (state == StPayload) begin
      pay_now[cnt] = rxData;
    end
  end

`ifdef CMD_CHECKSUM_EN
  assign exec_now = rxReady && (state == StCsum);
  assign exec_ok  = (csum == rxData);
`else
  assign exec_now = rxReady && (state == StPayload) && (cnt == last_idx);
  assign exec_ok  = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= StIdle;
      cmd      <= 8'h00;
      cnt      <= 3'd0;
      pay      <= '{default: 8'h00};
      steps    <= 9'd0;
      tmo      <= '0;
      romWrite <= 1'b0;
      romAddr  <= '0;
      romData  <= '0;
      stepClk  <= 1'b1;
      running  <= 1'b0;
      ackValid <= 1'b0;
      ackCode  <= 8'h00;
      errFlag  <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      romWrite <= 1'b0;
      ackValid <= 1'b0;
      // Free-run toggles every edge. Otherwise the clock parks high. The step
      // states below override this.
      stepClk  <= running ? ~stepClk : 1'b1;

      if (rxReady || !waiting) begin
        tmo <= '0;
      end else begin
        tmo <= tmo + 1'b1;
      end

      case (state)
        StIdle: begin
          if (rxReady) begin
            if (rxData == CmdWrite || rxData == CmdStep || rxData == CmdRun) begin
              cmd   <= rxData;
              cnt   <= 3'd0;
              state <= StPayload;
`ifdef CMD_CHECKSUM_EN
              csum  <= rxData;
`endif
            end else if (ackValid) begin
              // An ack is already on the wire this cycle. A back-to-back
              // NAK is not allowed, so the byte is dropped.
              errFlag <= 1'b1;
            end else begin
              ackValid <= 1'b1;
              ackCode  <= NakByte;
            end
          end
        end

        StPayload: begin
          if (rxReady) begin
            pay[cnt] <= rxData;
            cnt      <= cnt + 1'b1;
`ifdef CMD_CHECKSUM_EN
            csum     <= csum ^ rxData;
            if (cnt == last_idx) begin
              state <= StCsum;
            end
`endif
          end
        end

        StCsum: begin
          // Held here until the check byte arrives or the timeout fires.
        end

        StExec: begin
          if (rxReady) begin
            errFlag <= 1'b1;
          end
          state <= StIdle;
        end

        StStepLo: begin
          if (rxReady) begin
            errFlag <= 1'b1;
          end
          stepClk <= 1'b1;
          state   <= StStepHi;
        end

        StStepHi: begin
          if (rxReady) begin
            errFlag <= 1'b1;
          end
          if (steps == 9'd1) begin
            ackValid <= 1'b1;
            ackCode  <= AckByte;
            state    <= StExec;
          end else begin
            stepClk <= 1'b0;
            steps   <= steps - 9'd1;
            state   <= StStepLo;
          end
        end

        default: state <= StIdle;
      endcase

      // Partial packet is dropped. The ROM outputs are left untouched.
      if (timed_out) begin
        ackValid <= 1'b1;
        ackCode  <= NakByte;
        state    <= StIdle;
      end

      if (exec_now) begin
        ackValid <= 1'b1;
        ackCode  <= AckByte;
        state    <= StExec;
        if (!exec_ok) begin
          ackCode <= NakByte;
        end else if (cmd == CmdWrite) begin
          romWrite <= 1'b1;
          romAddr  <= ADDR_W'({pay_now[1], pay_now[0]});
          romData  <= WORD_W'({pay_now[5], pay_now[4], pay_now[3], pay_now[2]});
        end else if (cmd == CmdStep) begin
          if (running) begin
            ackCode <= NakByte;
          end else begin
            // The ack is deferred until the last high phase completes.
            ackValid <= 1'b0;
            stepClk  <= 1'b0;
            steps    <= (pay_now[0] == 8'h00) ? 9'd256 : {1'b0, pay_now[0]};
            state    <= StStepLo;
          end
        end else begin
          running <= pay_now[0][0];
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_debug_loader.sv
// Testbench for uart_debug_loader. It runs a short directed sequence, then
// random packets. Results are compared against a packet-level reference model.
// Honours CMD_CHECKSUM_EN if defined.
module tb_uart_debug_loader;

  localparam int unsigned Tmo = 40;
`ifdef CMD_CHECKSUM_EN
  localparam bit CsumOn = 1'b1;
`else
  localparam bit CsumOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rom_write;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;
  logic        step_clk;
  logic        running;
  logic        ack_valid;
  logic [7:0]  ack_code;
  logic        err_flag;

  uart_debug_loader #(
    .TIMEOUT_CYCLES(Tmo),
    .ADDR_W        (16),
    .WORD_W        (32)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .rxData  (rx_data),
    .rxReady (rx_ready),
    .romWrite(rom_write),
    .romAddr (rom_addr),
    .romData (rom_data),
    .stepClk (step_clk),
    .running (running),
    .ackValid(ack_valid),
    .ackCode (ack_code),
    .errFlag (err_flag)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the current clock period between rising edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int         rw_cnt  = 0;
  int         rw_cyc  = 0;
  int         low_cnt = 0;
  int         ack_cnt = 0;
  int         ack_cyc = 0;
  int         dbl_ack = 0;
  int         dbl_low = 0;
  logic [7:0] ack_seen = 8'h00;
  logic       prev_ack = 1'b0;
  logic       prev_step = 1'b1;

  always @(negedge clk) begin
    if (rom_write === 1'b1) begin
      rw_cnt <= rw_cnt + 1;
      rw_cyc <= cyc;
    end
    if (step_clk === 1'b0) begin
      low_cnt <= low_cnt + 1;
      if (prev_step === 1'b0) dbl_low <= dbl_low + 1;
    end
    if (ack_valid === 1'b1) begin
      ack_cnt  <= ack_cnt + 1;
      ack_cyc  <= cyc;
      ack_seen <= ack_code;
      if (prev_ack === 1'b1) dbl_ack <= dbl_ack + 1;
    end
    prev_ack  <= ack_valid;
    prev_step <= step_clk;
  end

  int         n_chk  = 0;
  int         n_fail = 0;
  int         last_rx = 0;
  logic [7:0] pkt [8];
  int         pkt_len = 0;
  bit         bad_csum = 1'b0;

  // Reference model state
  logic [15:0] m_addr = 16'h0000;
  logic [31:0] m_data = 32'h0;
  bit          m_run  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called one time unit after a rising edge. The byte is sampled on the next edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    last_rx  = cyc;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic set_pkt(input int len, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                         input logic [7:0] b5, input logic [7:0] b6);
    pkt_len = len;
    pkt[0] = b0; pkt[1] = b1; pkt[2] = b2; pkt[3] = b3;
    pkt[4] = b4; pkt[5] = b5; pkt[6] = b6; pkt[7] = 8'h00;
  endtask

  task automatic send_pkt;
    for (int i = 0; i < pkt_len; i++) begin
      send_byte(pkt[i]);
      if (i != pkt_len - 1) idle($urandom_range(0, 4));
    end
`ifdef CMD_CHECKSUM_EN
    if (pkt[0] inside {8'h01, 8'h02, 8'h03}) begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < pkt_len; i++) x = x ^ pkt[i];
      idle($urandom_range(0, 4));
      send_byte(bad_csum ? (x ^ 8'h5A) : x);
    end
`endif
  endtask

  task automatic wait_ack(input int base, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ack_cnt != base) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rw0, low0, ack0, tog, kind, nstep;
    bit  got, rejected, run_before;
    logic [7:0] c, m, prev;

    rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_romWrite", rom_write, 0);
    check("rst_romAddr", rom_addr, 0);
    check("rst_romData", rom_data, 0);
    check("rst_stepClk", step_clk, 1);
    check("rst_running", running, 0);
    check("rst_ackValid", ack_valid, 0);
    check("rst_ackCode", ack_code, 0);
    check("rst_errFlag", err_flag, 0);
    rst = 1'b0;
    idle(2);

    // WRITE 01 34 12 EF BE AD DE
    rw0 = rw_cnt; ack0 = ack_cnt; bad_csum = 1'b0;
    set_pkt(7, 8'h01, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_pkt();
    wait_ack(ack0, 20, got);
    check("wr_ack_seen", got, 1);
    check("wr_ack_code", ack_seen, 8'h06);
    check("wr_pulses", rw_cnt - rw0, 1);
    check("wr_latency", rw_cyc - last_rx, 1);
    check("wr_ack_same_cycle", ack_cyc, rw_cyc);
    check("wr_addr", rom_addr, 16'h1234);
    check("wr_data", rom_data, 32'hDEADBEEF);
    m_addr = 16'h1234; m_data = 32'hDEADBEEF;
    idle(3);

    // STEP 3
    low0 = low_cnt; ack0 = ack_cnt;
    set_pkt(2, 8'h02, 8'h03, 0, 0, 0, 0, 0);
    send_pkt();
    wait_ack(ack0, 40, got);
    check("step3_ack_seen", got, 1);
    check("step3_ack_code", ack_seen, 8'h06);
    check("step3_lows", low_cnt - low0, 3);
    check("step3_ack_latency", ack_cyc - last_rx, 7);
    idle(3);
    check("step3_one_ack", ack_cnt - ack0, 1);

    // STEP 0 means 256
    low0 = low_cnt; ack0 = ack_cnt;
    set_pkt(2, 8'h02, 8'h00, 0, 0, 0, 0, 0);
    send_pkt();
    wait_ack(ack0, 700, got);
    check("step256_ack_seen", got, 1);
    check("step256_lows", low_cnt - low0, 256);
    check("step256_ack_latency", ack_cyc - last_rx, 513);
    idle(3);

    // Unknown command, then a WRITE that must still work
    rw0 = rw_cnt; ack0 = ack_cnt;
    send_byte(8'h7F);
    wait_ack(ack0, 10, got);
    check("unk_ack_seen", got, 1);
    check("unk_nak", ack_seen, 8'h15);
    check("unk_latency", ack_cyc - last_rx, 1);
    idle(3);
    check("unk_no_write", rw_cnt - rw0, 0);
    ack0 = ack_cnt;
    set_pkt(7, 8'h01, 8'h78, 8'h56, 8'h44, 8'h33, 8'h22, 8'h11);
    send_pkt();
    wait_ack(ack0, 20, got);
    check("unk_next_ack", ack_seen, 8'h06);
    check("unk_next_addr", rom_addr, 16'h5678);
    check("unk_next_data", rom_data, 32'h11223344);
    m_addr = 16'h5678; m_data = 32'h11223344;
    idle(3);

    // Timeout after a partial packet
    rw0 = rw_cnt; ack0 = ack_cnt;
    send_byte(8'h01);
    send_byte(8'h34);
    wait_ack(ack0, Tmo + 20, got);
    check("tmo_ack_seen", got, 1);
    check("tmo_nak", ack_seen, 8'h15);
    check("tmo_latency", ack_cyc - last_rx, Tmo);
    check("tmo_no_write", rw_cnt - rw0, 0);
    check("tmo_addr_kept", rom_addr, m_addr);
    idle(3);

    // Free run, rejected step, stop
    ack0 = ack_cnt;
    set_pkt(2, 8'h03, 8'h01, 0, 0, 0, 0, 0);
    send_pkt();
    wait_ack(ack0, 20, got);
    check("run_ack", ack_seen, 8'h06);
    check("run_on", running, 1);
    m_run = 1'b1;
    tog = 0; prev = {7'd0, step_clk};
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if ({7'd0, step_clk} != prev) tog++;
      prev = {7'd0, step_clk};
    end
    check("run_toggles", tog, 6);
    idle(2);
    ack0 = ack_cnt;
    set_pkt(2, 8'h02, 8'h01, 0, 0, 0, 0, 0);
    send_pkt();
    wait_ack(ack0, 20, got);
    check("step_while_run_nak", ack_seen, 8'h15);
    check("step_while_run_still", running, 1);
    idle(2);
    ack0 = ack_cnt;
    set_pkt(2, 8'h03, 8'h00, 0, 0, 0, 0, 0);
    send_pkt();
    wait_ack(ack0, 20, got);
    check("stop_ack", ack_seen, 8'h06);
    check("stop_running", running, 0);
    m_run = 1'b0;
    idle(2);
    low0 = low_cnt;
    idle(5);
    check("stop_parked_high", step_clk, 1);
    check("stop_no_lows", low_cnt - low0, 0);

`ifdef CMD_CHECKSUM_EN
    low0 = low_cnt; ack0 = ack_cnt;
    pkt_len = 2; pkt[0] = 8'h02; pkt[1] = 8'h01;
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h03);
    wait_ack(ack0, 20, got);
    check("csum_good_ack", ack_seen, 8'h06);
    check("csum_good_step", low_cnt - low0, 1);
    idle(3);
    low0 = low_cnt; ack0 = ack_cnt;
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
    wait_ack(ack0, 20, got);
    check("csum_bad_nak", ack_seen, 8'h15);
    idle(3);
    check("csum_bad_no_step", low_cnt - low0, 0);
`endif

    // Random packets against the reference model
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 3);
      bad_csum = ($urandom_range(0, 5) == 0);
      run_before = m_run;
      rw0 = rw_cnt; low0 = low_cnt; ack0 = ack_cnt;
      nstep = 0;
      case (kind)
        0: set_pkt(7, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom));
        1: begin
          m = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 6));
          nstep = (m == 8'h00) ? 256 : int'(m);
          set_pkt(2, 8'h02, m, 0, 0, 0, 0, 0);
        end
        2: set_pkt(2, 8'h03, 8'($urandom), 0, 0, 0, 0, 0);
        default: begin
          c = 8'($urandom);
          while (c inside {8'h01, 8'h02, 8'h03}) c = 8'($urandom);
          set_pkt(1, c, 0, 0, 0, 0, 0, 0);
        end
      endcase
      rejected = (kind == 3) || (CsumOn && bad_csum) || (kind == 1 && m_run);
      if (!rejected) begin
        if (kind == 0) begin
          m_addr = {pkt[2], pkt[1]};
          m_data = {pkt[6], pkt[5], pkt[4], pkt[3]};
        end
        if (kind == 2) m_run = pkt[1][0];
      end
      send_pkt();
      wait_ack(ack0, 700, got);
      check("rnd_ack_seen", got, 1);
      check("rnd_ack_code", ack_seen, rejected ? 8'h15 : 8'h06);
      idle(2 + $urandom_range(0, 3));
      check("rnd_one_ack", ack_cnt - ack0, 1);
      check("rnd_addr", rom_addr, m_addr);
      check("rnd_data", rom_data, m_data);
      check("rnd_running", running, m_run);
      check("rnd_writes", rw_cnt - rw0, (kind == 0 && !rejected) ? 1 : 0);
      if (kind == 1 && !run_before) check("rnd_steps", low_cnt - low0, rejected ? 0 : nstep);
    end
    check("rnd_no_err", err_flag, 0);

    // Ensure stepping is allowed, then drop a byte mid-step
    ack0 = ack_cnt; bad_csum = 1'b0;
    set_pkt(2, 8'h03, 8'h00, 0, 0, 0, 0, 0);
    send_pkt();
    wait_ack(ack0, 20, got);
    m_run = 1'b0;
    idle(3);
    low0 = low_cnt; ack0 = ack_cnt;
    set_pkt(2, 8'h02, 8'h05, 0, 0, 0, 0, 0);
    send_pkt();
    idle(2);
    send_byte(8'h7F);
    wait_ack(ack0, 40, got);
    check("busy_step_ack", ack_seen, 8'h06);
    idle(4);
    check("busy_step_lows", low_cnt - low0, 5);
    check("busy_one_ack", ack_cnt - ack0, 1);
    check("busy_errflag", err_flag, 1);

    // Reset in the middle of a packet
    send_byte(8'h01); send_byte(8'h34); send_byte(8'h12);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    m_addr = 16'h0000; m_data = 32'h0; m_run = 1'b0;
    ack0 = ack_cnt;
    idle(Tmo + 10);
    check("rstpkt_no_ack", ack_cnt - ack0, 0);
    check("rstpkt_addr", rom_addr, 16'h0000);
    check("rstpkt_errflag", err_flag, 0);
    set_pkt(7, 8'h01, 8'hCD, 8'hAB, 8'h78, 8'h56, 8'h34, 8'h12);
    send_pkt();
    wait_ack(ack0, 20, got);
    check("rstpkt_next_addr", rom_addr, 16'hABCD);
    check("rstpkt_next_data", rom_data, 32'h12345678);
    idle(3);

    // Reset in the middle of a step burst
    set_pkt(2, 8'h02, 8'h10, 0, 0, 0, 0, 0);
    send_pkt();
    idle(4);
    rst = 1'b1;
    idle(1);
    check("rststep_high", step_clk, 1);
    rst = 1'b0;
    low0 = low_cnt; ack0 = ack_cnt;
    idle(40);
    check("rststep_no_ack", ack_cnt - ack0, 0);
    check("rststep_no_lows", low_cnt - low0, 0);

    check("never_double_ack", dbl_ack, 0);
    check("never_double_low", dbl_low, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
